// File: rtl/simd_data_mem.sv
// Data memory for the SIMD CPU: valid/ready request port, nibble write masks,
// RD_LAT-cycle read pipe and a first-word-fall-through response FIFO with credit flow control.
module simd_data_mem #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = RD_LAT + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W/4-1:0] req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int LANES = DATA_W / 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  if ((DATA_W % 4) != 0 || DEPTH > (1 << ADDR_W) || RD_LAT < 1 || RD_LAT > 4 ||
      RSP_DEPTH < 1) begin : g_param_error
    $error("simd_data_mem: invalid parameter combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic [DATA_W-1:0] rd_word;
  logic              rd_err;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              push_err;

  logic [CNT_W-1:0]  fifo_count_reg;
  logic [CNT_W-1:0]  occ_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [DATA_W-1:0] fifo_data_reg [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_reg;

  assign mem_idx  = req_addr[IDX_W-1:0];
  assign in_range = (32'(req_addr) < 32'(DEPTH));

  // occ_reg tracks reads in the pipe plus queued responses, so every accepted read has a FIFO slot.
  assign req_ready = rst && (occ_reg < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign wr_accept = accept && req_we && in_range;

  assign rd_word = in_range ? mem[mem_idx] : '0;
  assign rd_err  = !in_range;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_mask[i]) begin
          mem[mem_idx][4*i +: 4] <= req_wdata[4*i +: 4];
        end
      end
    end
  end

  // With RD_LAT=1 the array word goes straight into the FIFO at the accept edge.
  if (RD_LAT == 1) begin : g_nopipe
    assign push      = rd_accept;
    assign push_data = rd_word;
    assign push_err  = rd_err;
  end else begin : g_pipe
    logic [RD_LAT-2:0] pv_reg;
    logic [RD_LAT-2:0] pe_reg;
    logic [DATA_W-1:0] pd_reg [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        pv_reg <= '0;
      end else begin
        pv_reg[0] <= rd_accept;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          pv_reg[i] <= pv_reg[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pe_reg[0] <= rd_err;
      pd_reg[0] <= rd_word;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        pe_reg[i] <= pe_reg[i-1];
        pd_reg[i] <= pd_reg[i-1];
      end
    end

    assign push      = pv_reg[RD_LAT-2];
    assign push_data = pd_reg[RD_LAT-2];
    assign push_err  = pe_reg[RD_LAT-2];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rsp_valid = (fifo_count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;
  assign rsp_err   = rsp_valid && fifo_err_reg[rd_ptr_reg];
  assign busy      = (occ_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= push_data;
      fifo_err_reg[wr_ptr_reg]  <= push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      occ_reg        <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      case ({rd_accept, pop})
        2'b10:   occ_reg <= occ_reg + CNT_W'(1);
        2'b01:   occ_reg <= occ_reg - CNT_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_data_mem.sv
// Directed bench for simd_data_mem: three instances (default, RD_LAT=3/RSP_DEPTH=4/DEPTH=512,
// RD_LAT=4) share the request bus, each with its own valid and rsp_ready.
module tb_simd_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vv;
  logic [2:0]  rk;
  logic        we;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic [3:0]  mask;
  wire  [2:0]  rr, rv, re, bz;
  wire  [15:0] rd0, rd1, rd2;

  int vectors = 0;
  int fails   = 0;
  int outst [3];

  always #5 clk = ~clk;

  simd_data_mem u_a (
    .clk(clk), .rst(rst), .req_valid(vv[0]), .req_ready(rr[0]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_mask(mask), .rsp_valid(rv[0]),
    .rsp_ready(rk[0]), .rsp_data(rd0), .rsp_err(re[0]), .busy(bz[0]));

  simd_data_mem #(.DEPTH(512), .RD_LAT(3), .RSP_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .req_valid(vv[1]), .req_ready(rr[1]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_mask(mask), .rsp_valid(rv[1]),
    .rsp_ready(rk[1]), .rsp_data(rd1), .rsp_err(re[1]), .busy(bz[1]));

  simd_data_mem #(.RD_LAT(4)) u_c (
    .clk(clk), .rst(rst), .req_valid(vv[2]), .req_ready(rr[2]), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_mask(mask), .rsp_valid(rv[2]),
    .rsp_ready(rk[2]), .rsp_data(rd2), .rsp_err(re[2]), .busy(bz[2]));

  function automatic logic [15:0] get_rd(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic int dep(input int d);
    case (d)
      0:       return 2;
      1:       return 4;
      default: return 5;
    endcase
  endfunction

  // Outstanding reads (accepted minus popped) must never exceed the FIFO depth.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst !== 1'b1) begin
        outst[d] = 0;
      end else begin
        if (vv[d] && rr[d] && !we) outst[d]++;
        if (rv[d] && rk[d]) outst[d]--;
        if (outst[d] > dep(d)) begin
          fails++;
          $display("FAIL overflow dut%0d: outstanding %0d, limit %0d", d, outst[d], dep(d));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int d, input logic [9:0] a, input logic [15:0] w,
                          input logic [3:0] m);
    we = 1'b1; addr = a; wdata = w; mask = m; vv[d] = 1'b1;
    cyc();
    vv[d] = 1'b0; we = 1'b0;
    $display("write dut%0d addr %0d data %h mask %b", d, a, w, m);
  endtask

  task automatic do_read(input int d, input logic [9:0] a, output logic [15:0] data,
                         output logic err, output int lat);
    we = 1'b0; addr = a; vv[d] = 1'b1;
    cyc();
    vv[d] = 1'b0;
    lat = 0;
    while (!rv[d] && lat < 20) begin
      cyc();
      lat++;
    end
    data = get_rd(d);
    err  = re[d];
    $display("read  dut%0d addr %0d data %h err %0b lat %0d", d, a, data, err, lat);
    if (rv[d]) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0; vv = '0; rk = 3'b111; we = 1'b0; addr = '0; wdata = '0; mask = '0;
    cyc();
    cyc();
    vectors++;
    if (rr !== 3'b000) begin fails++; $display("FAIL reset_ready_low: got %b, want 000", rr); end
    vectors++;
    if (rv !== 3'b000) begin fails++; $display("FAIL reset_rsp_valid: got %b, want 000", rv); end
    vectors++;
    if (bz !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b, want 000", bz); end
    vectors++;
    if (re !== 3'b000) begin fails++; $display("FAIL reset_rsp_err: got %b, want 000", re); end
    vectors++;
    if ({rd0, rd1, rd2} !== 48'h0) begin
      fails++; $display("FAIL reset_rsp_data: got %h %h %h, want 0", rd0, rd1, rd2);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (rr !== 3'b111) begin fails++; $display("FAIL reset_ready_high: got %b, want 111", rr); end
  endtask

  task automatic test_basic_read();
    logic [15:0] exp_v;
    do_write(0, 10'd0, 16'd5, 4'hF);
    do_write(0, 10'd1, 16'd15, 4'hF);
    do_write(0, 10'd2, 16'd4, 4'hF);
    for (int i = 0; i < 3; i++) begin
      exp_v = (i == 0) ? 16'd5 : (i == 1) ? 16'd15 : 16'd4;
      we = 1'b0; addr = 10'(i); vv[0] = 1'b1;
      vectors++;
      if (rr[0] !== 1'b1) begin fails++; $display("FAIL basic_ready[%0d]: got %b, want 1", i, rr[0]); end
      cyc();
      vectors++;
      if (rv[0] !== 1'b1 || rd0 !== exp_v || re[0] !== 1'b0) begin
        fails++;
        $display("FAIL basic_rsp[%0d]: got v=%b d=%h e=%b, want v=1 d=%h e=0", i, rv[0], rd0, re[0], exp_v);
      end
      $display("read  dut0 addr %0d data %h back-to-back", i, rd0);
    end
    vv[0] = 1'b0;
    cyc();
    vectors++;
    if (rv[0] !== 1'b0 || bz[0] !== 1'b0) begin
      fails++; $display("FAIL basic_drain: got v=%b busy=%b, want 0 0", rv[0], bz[0]);
    end
  endtask

  task automatic test_lane_mask();
    logic [15:0] d;
    logic        e;
    int          lat;
    do_write(0, 10'd3, 16'h013A, 4'hF);
    do_write(0, 10'd3, 16'hFFFF, 4'b0101);
    do_read(0, 10'd3, d, e, lat);
    vectors++;
    if (d !== 16'h0F3F || e !== 1'b0) begin
      fails++; $display("FAIL mask_0101: got %h err %b, want 0f3f err 0", d, e);
    end
    vectors++;
    if (lat !== 0) begin fails++; $display("FAIL mask_latency: got %0d, want 0", lat); end
    do_write(0, 10'd3, 16'h1234, 4'b0000);
    do_read(0, 10'd3, d, e, lat);
    vectors++;
    if (d !== 16'h0F3F) begin fails++; $display("FAIL mask_0000: got %h, want 0f3f", d); end
  endtask

  task automatic test_raw();
    do_write(0, 10'd5, 16'h0BAD, 4'hF);
    we = 1'b1; addr = 10'd5; wdata = 16'h0014; mask = 4'hF; vv[0] = 1'b1;
    cyc();
    we = 1'b0;
    cyc();
    vv[0] = 1'b0;
    $display("read  dut0 addr 5 data %h after write", rd0);
    vectors++;
    if (rv[0] !== 1'b1 || rd0 !== 16'h0014) begin
      fails++; $display("FAIL raw: got v=%b d=%h, want v=1 d=0014", rv[0], rd0);
    end
    cyc();
  endtask

  task automatic test_out_of_range();
    logic [15:0] d;
    logic        e;
    int          lat;
    do_write(1, 10'd88, 16'h1234, 4'hF);
    do_write(1, 10'd600, 16'hAAAA, 4'hF);
    do_read(1, 10'd600, d, e, lat);
    vectors++;
    if (d !== 16'h0000 || e !== 1'b1) begin
      fails++; $display("FAIL oor_read: got %h err %b, want 0000 err 1", d, e);
    end
    vectors++;
    if (lat !== 2) begin fails++; $display("FAIL oor_latency: got %0d, want 2", lat); end
    do_read(1, 10'd88, d, e, lat);
    vectors++;
    if (d !== 16'h1234 || e !== 1'b0) begin
      fails++; $display("FAIL oor_alias: got %h err %b, want 1234 err 0", d, e);
    end
    do_write(1, 10'd511, 16'h5A5A, 4'hF);
    do_read(1, 10'd511, d, e, lat);
    vectors++;
    if (d !== 16'h5A5A || e !== 1'b0) begin
      fails++; $display("FAIL top_word: got %h err %b, want 5a5a err 0", d, e);
    end
    do_read(1, 10'd512, d, e, lat);
    vectors++;
    if (d !== 16'h0000 || e !== 1'b1) begin
      fails++; $display("FAIL first_oor: got %h err %b, want 0000 err 1", d, e);
    end
  endtask

  task automatic test_backpressure();
    int          nxt;
    int          got;
    logic        acc;
    logic        pp;
    logic [15:0] pdat;
    for (int i = 0; i < 6; i++) do_write(1, 10'(i), 16'h0C00 + 16'(i), 4'hF);
    rk[1] = 1'b0; we = 1'b0; nxt = 0;
    for (int c = 0; c < 10; c++) begin
      vv[1] = (nxt < 6);
      addr  = 10'(nxt);
      acc   = vv[1] && rr[1];
      cyc();
      if (acc) nxt++;
    end
    vv[1] = 1'b0;
    $display("stall dut1 accepted %0d ready %b head %h", nxt, rr[1], rd1);
    vectors++;
    if (nxt !== 4) begin fails++; $display("FAIL bp_accepted: got %0d, want 4", nxt); end
    vectors++;
    if (rr[1] !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b, want 0", rr[1]); end
    vectors++;
    if (rv[1] !== 1'b1 || rd1 !== 16'h0C00 || re[1] !== 1'b0) begin
      fails++; $display("FAIL bp_head_hold: got v=%b d=%h e=%b, want v=1 d=0c00 e=0", rv[1], rd1, re[1]);
    end
    rk[1] = 1'b1; got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      vv[1] = (nxt < 6);
      addr  = 10'(nxt);
      acc   = vv[1] && rr[1];
      pp    = rv[1];
      pdat  = rd1;
      cyc();
      if (acc) nxt++;
      if (pp) begin
        $display("pop   dut1 #%0d data %h", got, pdat);
        vectors++;
        if (pdat !== 16'h0C00 + 16'(got)) begin
          fails++; $display("FAIL bp_order[%0d]: got %h, want %h", got, pdat, 16'h0C00 + 16'(got));
        end
        got++;
        if (got == 6) begin
          vectors++;
          if (bz[1] !== 1'b0) begin fails++; $display("FAIL bp_busy_end: got %b, want 0", bz[1]); end
        end
      end
    end
    vv[1] = 1'b0;
    vectors++;
    if (got !== 6) begin fails++; $display("FAIL bp_count: got %0d responses, want 6", got); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic        e;
    int          lat;
    logic        stale;
    do_write(2, 10'd10, 16'h0A0A, 4'hF);
    do_write(2, 10'd11, 16'h0B0B, 4'hF);
    do_write(2, 10'd12, 16'h0C0C, 4'hF);
    do_write(2, 10'd20, 16'h0777, 4'hF);
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 10'd10 + 10'(i); vv[2] = 1'b1;
      cyc();
    end
    vectors++;
    if (bz[2] !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b, want 1", bz[2]); end
    rst = 1'b0; we = 1'b1; addr = 10'd20; wdata = 16'hDEAD; mask = 4'hF; vv[2] = 1'b1;
    #1;
    vectors++;
    if (rr[2] !== 1'b0) begin fails++; $display("FAIL rstmid_ready_low: got %b, want 0", rr[2]); end
    cyc();
    rst = 1'b1; vv[2] = 1'b0; we = 1'b0;
    #1;
    $display("reset dut2 valid %b busy %b ready %b", rv[2], bz[2], rr[2]);
    vectors++;
    if (rv[2] !== 1'b0 || bz[2] !== 1'b0 || rr[2] !== 1'b1) begin
      fails++; $display("FAIL rstmid_flags: got v=%b busy=%b rdy=%b, want 0 0 1", rv[2], bz[2], rr[2]);
    end
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (rv[2] !== 1'b0) stale = 1'b1;
    end
    vectors++;
    if (stale !== 1'b0) begin fails++; $display("FAIL rstmid_stale: got %b, want 0", stale); end
    do_read(2, 10'd11, d, e, lat);
    vectors++;
    if (d !== 16'h0B0B || e !== 1'b0) begin
      fails++; $display("FAIL rstmid_preserved: got %h err %b, want 0b0b err 0", d, e);
    end
    vectors++;
    if (lat !== 3) begin fails++; $display("FAIL rstmid_latency: got %0d, want 3", lat); end
    do_read(2, 10'd20, d, e, lat);
    vectors++;
    if (d !== 16'h0777) begin fails++; $display("FAIL rstmid_write_dropped: got %h, want 0777", d); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_lane_mask();
    test_raw();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simd_data_mem.md
# simd_data_mem

Parametrised, synthesizable data memory for the SIMD CPU. It replaces the always-ready, fixed-latency negedge memory model with a posedge valid/ready request port, configurable read latency, and a response FIFO with backpressure. Nibble-granular lane write masks let 4-bit (Q), 8-bit (O) and 16-bit (H) stores update only their own lanes. It sits between the CPU data port (data_address / data_out / data_in) and on-chip RAM.

## Interface

**Parameters**
- DATA_W, 16: word width. Must be a multiple of 4.
- ADDR_W, 10: address width.
- DEPTH, 1024: implemented words. Must be ≤ 2^ADDR_W.
- RD_LAT, 1: cycles from request accept to response-FIFO write. Range 1..4.
- RSP_DEPTH, RD_LAT+1: response FIFO entries. Must be ≥ 1.

**Ports**
- clk, input, 1: system clock. All logic is posedge.
- rst, input, 1: reset, synchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: request can be accepted.
- req_we, input, 1: 1 = write, 0 = read.
- req_addr, input, ADDR_W: word address.
- req_wdata, input, DATA_W: write data.
- req_mask, input, DATA_W/4: write enable per nibble. Bit i covers bits [4i+3:4i].
- rsp_valid, output, 1: read response available.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, DATA_W: read data.
- rsp_err, output, 1: the response is for an out-of-range address.
- busy, output, 1: a read is in flight or the FIFO is non-empty.

## Operation

**Accept**
- A request is accepted when req_valid && req_ready on a posedge.
- Requests are served strictly in order. There is one array port and at most one access per cycle.

**Credit rule**
- req_ready = (inflight + fifo_count) < RSP_DEPTH.
- inflight is the number of reads in the latency pipe.
- req_ready is driven from registers only. There is no combinational path from rsp_ready or req_valid.
- This credit limit applies to writes as well. Writes never enter the pipe or the FIFO.

**Write**
- For each i with req_mask[i]=1, mem[addr][4i+3:4i] ← wdata[4i+3:4i]. Nibbles with mask 0 are unchanged.
- Mask all-zero: no-op.
- Writes produce no response.

**Read**
- Array data is captured at the accept edge.
- It passes through a shift pipe of RD_LAT−1 additional stages, each with a valid bit and an err bit.
- It is then written into the FIFO.

**Out of range (addr ≥ DEPTH)**
- Write: ignored.
- Read: returns rsp_data = 0 with rsp_err = 1.

**Response FIFO**
- First-word-fall-through.
- rsp_valid = fifo_count ≠ 0.
- rsp_data and rsp_err show the head entry.
- The head pops on rsp_valid && rsp_ready.
- A push and a pop in the same cycle leave the count unchanged.
- The credit rule makes overflow impossible. An overflow is an RTL bug and is covered by an assertion in the bench.

**Read-after-write**
- A read accepted the cycle after a write to the same address returns the new data.
- A read accepted in the same cycle cannot occur (single port).

**Reset (rst=0 at a posedge)**
- Pipe valids and FIFO count are cleared.
- Outputs: req_ready=1 (0 while rst=0 is sampled), rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
- Memory contents are not cleared.
- Reset mid-operation discards all in-flight reads and queued responses. No response for them ever appears.
- A write accepted at the reset edge is not performed.

## Timing

- Read accepted at edge t → response pushed at edge t+RD_LAT−1 → rsp_valid=1 in the cycle after edge t+RD_LAT−1. This holds when the FIFO is empty or being drained.
- RD_LAT=1: the response is visible one cycle after accept.
- Throughput: one read per cycle sustained while rsp_ready=1 and RSP_DEPTH ≥ RD_LAT+1.
- With RSP_DEPTH = RD_LAT, a one-cycle bubble is allowed between bursts.
- Backpressure: rsp_ready=0 holds rsp_data and rsp_err stable. req_ready drops once the credits are exhausted. Nothing is lost or reordered.
- busy = (inflight ≠ 0) || (fifo_count ≠ 0). The CPU uses busy=0 before asserting done.

## Test plan

1. Basic read, defaults.
   - Stimulus: preload mem[0]=5, mem[1]=15, mem[2]=4; read 0, 1, 2 back-to-back with rsp_ready=1.
   - Required: rsp_data is 5, 15, 4 on consecutive cycles, first one cycle after the first accept; rsp_err=0.
2. Lane mask.
   - Stimulus: mem[3]=0x013A; write 0xFFFF with mask 4'b0101; then read 3.
   - Required: read returns 0x0F3F.
   - Stimulus: mask 4'b0000.
   - Required: word unchanged.
3. Backpressure, RD_LAT=3, RSP_DEPTH=4.
   - Stimulus: issue 6 reads of addrs 0..5 with rsp_ready=0.
   - Required: exactly 4 accepted, then req_ready=0.
   - Stimulus: raise rsp_ready.
   - Required: responses in order 0..5 with no duplicates; busy falls after the last pop.
4. Out of range, DEPTH=512.
   - Stimulus: write 0xAAAA to addr 600, then read 600.
   - Required: rsp_data=0, rsp_err=1; mem[88] unchanged (no aliasing).
5. Read-after-write.
   - Stimulus: write 0x0014 to addr 5, then read 5 in the next cycle.
   - Required: read returns 0x0014.
6. Reset mid-operation.
   - Stimulus: RD_LAT=4; accept 3 reads; rst=0 for one edge.
   - Required: rsp_valid=0, busy=0, req_ready=1 after reset is released; no stale responses appear within 10 cycles; memory contents preserved.
